// File: rtl/axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_frame_arbiter
//
// Two-requester AXI4-Stream arbiter that grants the shared output one whole
// frame at a time. Arbitration happens in a dedicated IDLE cycle; while a
// requester owns the bus its beats pass straight through combinationally, and
// the grant is only released by an accepted tlast beat. Simultaneous requests
// alternate between the two requesters.
//
// Ports
//   s_axis_aclk      clock, everything on the rising edge
//   s_axis_aresetn   synchronous active-low reset
//   s0_axis_*        requester 0 stream (tdata/tstrb/tkeep/tvalid/tlast in,
//                    tready out)
//   s1_axis_*        requester 1 stream, same set as s0
//   m_axis_*         shared output stream (tready in, the rest out)
//   grant            one-hot owner from the state register: 01 s0, 10 s1,
//                    00 none
//   frame_cnt0/1     16-bit wrapping count of completed frames per requester
// -----------------------------------------------------------------------------
module axis_frame_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    s_axis_aclk,
   input  logic                    s_axis_aresetn,
   input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s0_axis_tstrb,
   input  logic [DATA_WIDTH/8-1:0] s0_axis_tkeep,
   input  logic                    s0_axis_tvalid,
   input  logic                    s0_axis_tlast,
   output logic                    s0_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s1_axis_tstrb,
   input  logic [DATA_WIDTH/8-1:0] s1_axis_tkeep,
   input  logic                    s1_axis_tvalid,
   input  logic                    s1_axis_tlast,
   output logic                    s1_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [1:0]              grant,
   output logic [15:0]             frame_cnt0,
   output logic [15:0]             frame_cnt1
);

   // One-hot encoding chosen so the state register doubles as the grant.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_owner;       // 0 = s0 owned last, 1 = s1 owned last
   logic        w_next_last_owner;
   logic        w_done0;            // s0 tlast beat accepted this cycle
   logic        w_done1;            // s1 tlast beat accepted this cycle
   logic [15:0] r_frame_cnt0;
   logic [15:0] r_frame_cnt1;

   assign grant      = 2'(r_state);
   assign frame_cnt0 = r_frame_cnt0;
   assign frame_cnt1 = r_frame_cnt1;

   // State and last-owner registers.
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         r_state      <= ST_IDLE;
         r_last_owner <= 1'b1;
      end else begin
         r_state      <= w_next_state;
         r_last_owner <= w_next_last_owner;
      end
   end

   // Next-state arbitration and zero-latency pass-through mux.
   always_comb begin
      w_next_state      = r_state;
      w_next_last_owner = r_last_owner;
      w_done0           = 1'b0;
      w_done1           = 1'b0;
      m_axis_tdata      = {DATA_WIDTH{1'b0}};
      m_axis_tstrb      = {(DATA_WIDTH/8){1'b0}};
      m_axis_tkeep      = {(DATA_WIDTH/8){1'b0}};
      m_axis_tvalid     = 1'b0;
      m_axis_tlast      = 1'b0;
      s0_axis_tready    = 1'b0;
      s1_axis_tready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (s0_axis_tvalid && s1_axis_tvalid) begin
               // Tie: the requester that did not own the bus last goes next.
               if (r_last_owner == 1'b1) begin
                  w_next_state      = ST_GNT0;
                  w_next_last_owner = 1'b0;
               end else begin
                  w_next_state      = ST_GNT1;
                  w_next_last_owner = 1'b1;
               end
            end else if (s0_axis_tvalid) begin
               w_next_state      = ST_GNT0;
               w_next_last_owner = 1'b0;
            end else if (s1_axis_tvalid) begin
               w_next_state      = ST_GNT1;
               w_next_last_owner = 1'b1;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_GNT0: begin
            m_axis_tdata   = s0_axis_tdata;
            m_axis_tstrb   = s0_axis_tstrb;
            m_axis_tkeep   = s0_axis_tkeep;
            m_axis_tvalid  = s0_axis_tvalid;
            m_axis_tlast   = s0_axis_tlast;
            s0_axis_tready = m_axis_tready;
            // Only an accepted tlast beat releases the grant.
            if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
               w_done0      = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_GNT0;
            end
         end
         ST_GNT1: begin
            m_axis_tdata   = s1_axis_tdata;
            m_axis_tstrb   = s1_axis_tstrb;
            m_axis_tkeep   = s1_axis_tkeep;
            m_axis_tvalid  = s1_axis_tvalid;
            m_axis_tlast   = s1_axis_tlast;
            s1_axis_tready = m_axis_tready;
            if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
               w_done1      = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_GNT1;
            end
         end
         default: begin
            // Unreachable encoding: fall back to a clean idle.
            w_next_state      = ST_IDLE;
            w_next_last_owner = 1'b1;
         end
      endcase
   end

   // Completed-frame counters, free-running modulo 2^16.
   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         r_frame_cnt0 <= 16'h0000;
         r_frame_cnt1 <= 16'h0000;
      end else begin
         if (w_done0) begin
            r_frame_cnt0 <= r_frame_cnt0 + 16'h0001;
         end else begin
            r_frame_cnt0 <= r_frame_cnt0;
         end
         if (w_done1) begin
            r_frame_cnt1 <= r_frame_cnt1 + 16'h0001;
         end else begin
            r_frame_cnt1 <= r_frame_cnt1;
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_arbiter
//
// Stimulus issues whole frames per requester; each frame's beats are pushed to
// that requester's expected queue. An independent negedge monitor runs a
// frame-level reference (who owns the bus, tie alternation, counts) and pops
// and compares every beat the DUT presents on m_axis.
// -----------------------------------------------------------------------------
module tb_axis_frame_arbiter;

   localparam int DW = 32;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic          last;
      logic [KW-1:0] keep;
      logic [KW-1:0] strb;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          aresetn;
   logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
   logic [KW-1:0] s0_tstrb, s0_tkeep, s1_tstrb, s1_tkeep, m_tstrb, m_tkeep;
   logic          s0_tvalid, s0_tlast, s0_tready;
   logic          s1_tvalid, s1_tlast, s1_tready;
   logic          m_tvalid, m_tlast, m_tready;
   logic [1:0]    grant;
   logic [15:0]   frame_cnt0, frame_cnt1;

   always #5 clk = ~clk;

   axis_frame_arbiter #(.DATA_WIDTH(DW)) dut (
      .s_axis_aclk    (clk),
      .s_axis_aresetn (aresetn),
      .s0_axis_tdata  (s0_tdata),
      .s0_axis_tstrb  (s0_tstrb),
      .s0_axis_tkeep  (s0_tkeep),
      .s0_axis_tvalid (s0_tvalid),
      .s0_axis_tlast  (s0_tlast),
      .s0_axis_tready (s0_tready),
      .s1_axis_tdata  (s1_tdata),
      .s1_axis_tstrb  (s1_tstrb),
      .s1_axis_tkeep  (s1_tkeep),
      .s1_axis_tvalid (s1_tvalid),
      .s1_axis_tlast  (s1_tlast),
      .s1_axis_tready (s1_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tstrb   (m_tstrb),
      .m_axis_tkeep   (m_tkeep),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tlast   (m_tlast),
      .m_axis_tready  (m_tready),
      .grant          (grant),
      .frame_cnt0     (frame_cnt0),
      .frame_cnt1     (frame_cnt1)
   );

   // Driver queues (beats still to send) and scoreboard queues (expected).
   beat_t drv_q0[$], drv_q1[$], exp_q0[$], exp_q1[$];
   int    owner_log[$];
   bit    tr_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   bit    mon_en = 1'b0;
   int    gap_pct = 0;
   bit    tr_rand = 1'b0;
   int    acc0 = 0;

   // Reference model state: 0 = nobody owns the bus, 1 = s0, 2 = s1.
   int          mdl_owner = 0;
   bit          mdl_last_owner = 1'b1;
   logic [15:0] mdl_cnt0 = 16'h0000;
   logic [15:0] mdl_cnt1 = 16'h0000;
   beat_t       mon_b;
   logic [1:0]  e_grant;
   logic        e_tv;
   bit          have_b;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: compare DUT against the model, then advance it.
   always @(negedge clk) begin
      if (mon_en) begin
         e_grant = (mdl_owner == 1) ? 2'b01 : (mdl_owner == 2) ? 2'b10 : 2'b00;
         e_tv    = (mdl_owner == 1) ? s0_tvalid : (mdl_owner == 2) ? s1_tvalid : 1'b0;
         chk("grant", 64'(grant), 64'(e_grant));
         chk("m_tvalid", 64'(m_tvalid), 64'(e_tv));
         chk("s0_tready", 64'(s0_tready), 64'((mdl_owner == 1) ? m_tready : 1'b0));
         chk("s1_tready", 64'(s1_tready), 64'((mdl_owner == 2) ? m_tready : 1'b0));
         chk("frame_cnt0", 64'(frame_cnt0), 64'(mdl_cnt0));
         chk("frame_cnt1", 64'(frame_cnt1), 64'(mdl_cnt1));
         have_b = 1'b0;
         if (e_tv) begin
            if ((mdl_owner == 1 && exp_q0.size() == 0) || (mdl_owner == 2 && exp_q1.size() == 0)) begin
               n_checks++;
               n_errors++;
               $display("FAIL scoreboard_empty: got beat %0h expected none at %0t", m_tdata, $time);
            end else begin
               mon_b  = (mdl_owner == 1) ? exp_q0[0] : exp_q1[0];
               have_b = 1'b1;
               chk("m_tdata", 64'(m_tdata), 64'(mon_b.data));
               chk("m_tstrb", 64'(m_tstrb), 64'(mon_b.strb));
               chk("m_tkeep", 64'(m_tkeep), 64'(mon_b.keep));
               chk("m_tlast", 64'(m_tlast), 64'(mon_b.last));
            end
         end else if (mdl_owner == 0) begin
            chk("m_tlast_idle", 64'(m_tlast), 64'd0);
         end
         if (!aresetn) begin
            mdl_owner      = 0;
            mdl_last_owner = 1'b1;
            mdl_cnt0       = 16'h0000;
            mdl_cnt1       = 16'h0000;
            exp_q0.delete();
            exp_q1.delete();
            owner_log.delete();
         end else if (mdl_owner != 0) begin
            if (have_b && m_tready) begin
               if (mdl_owner == 1) mon_b = exp_q0.pop_front();
               else mon_b = exp_q1.pop_front();
               if (mon_b.last) begin
                  if (mdl_owner == 1) mdl_cnt0 = mdl_cnt0 + 16'h0001;
                  else mdl_cnt1 = mdl_cnt1 + 16'h0001;
                  owner_log.push_back(mdl_owner);
                  mdl_owner = 0;
               end
            end
         end else begin
            if (s0_tvalid && s1_tvalid) mdl_owner = mdl_last_owner ? 1 : 2;
            else if (s0_tvalid) mdl_owner = 1;
            else if (s1_tvalid) mdl_owner = 2;
            if (mdl_owner != 0) mdl_last_owner = (mdl_owner == 2);
         end
      end
   end

   task automatic add_frame(input int src, input int len, input bit rnd, input logic [DW-1:0] base);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = rnd ? DW'($urandom) : base + DW'(i);
         b.strb = rnd ? KW'($urandom) : {KW{1'b1}};
         b.keep = rnd ? KW'($urandom) : {KW{1'b1}};
         b.last = (i == len - 1);
         if (src == 0) begin
            drv_q0.push_back(b);
            exp_q0.push_back(b);
         end else begin
            drv_q1.push_back(b);
            exp_q1.push_back(b);
         end
      end
   endtask

   // One clock: observe handshakes mid-cycle, then drive the next cycle's inputs.
   task automatic cycle();
      bit    hs0, hs1;
      beat_t tmp;
      @(negedge clk);
      hs0 = s0_tvalid && s0_tready;
      hs1 = s1_tvalid && s1_tready;
      @(posedge clk);
      #1;
      if (hs0) begin
         tmp = drv_q0.pop_front();
         acc0++;
      end
      if (hs1) tmp = drv_q1.pop_front();
      if (drv_q0.size() > 0) begin
         if (!(s0_tvalid && !hs0)) s0_tvalid = ($urandom_range(99) >= 32'(gap_pct));
         {s0_tlast, s0_tkeep, s0_tstrb, s0_tdata} = drv_q0[0];
      end else begin
         s0_tvalid = 1'b0;
         s0_tlast  = 1'b0;
      end
      if (drv_q1.size() > 0) begin
         if (!(s1_tvalid && !hs1)) s1_tvalid = ($urandom_range(99) >= 32'(gap_pct));
         {s1_tlast, s1_tkeep, s1_tstrb, s1_tdata} = drv_q1[0];
      end else begin
         s1_tvalid = 1'b0;
         s1_tlast  = 1'b0;
      end
      if (tr_q.size() > 0) m_tready = tr_q.pop_front();
      else m_tready = tr_rand ? 1'($urandom_range(1)) : 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((drv_q0.size() > 0 || drv_q1.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      n_checks++;
      if (n >= budget) begin
         n_errors++;
         $display("FAIL drain_timeout: got %0d cycles expected fewer than %0d", n, budget);
      end
      repeat (3) cycle();
   endtask

   task automatic do_reset(input int n);
      aresetn   = 1'b0;
      drv_q0.delete();
      drv_q1.delete();
      tr_q.delete();
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
      s0_tlast  = 1'b0;
      s1_tlast  = 1'b0;
      repeat (n) cycle();
      aresetn = 1'b1;
   endtask

   initial begin
      int n;
      int need;
      aresetn  = 1'b0;
      {s0_tdata, s0_tstrb, s0_tkeep, s0_tvalid, s0_tlast} = '0;
      {s1_tdata, s1_tstrb, s1_tkeep, s1_tvalid, s1_tlast} = '0;
      m_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (2) cycle();
      aresetn = 1'b1;
      chk("reset_grant", 64'(grant), 64'd0);
      chk("reset_cnt0", 64'(frame_cnt0), 64'd0);

      // Single source, four beats 1..4.
      add_frame(0, 4, 1'b0, 32'd1);
      drain(50);
      chk("single_cnt0", 64'(frame_cnt0), 64'd1);
      chk("single_cnt1", 64'(frame_cnt1), 64'd0);
      chk("single_frames", 64'(owner_log.size()), 64'd1);

      // Tie after reset: alternation s0, s1, s0, s1.
      do_reset(1);
      add_frame(0, 2, 1'b0, 32'h10);
      add_frame(1, 2, 1'b0, 32'h20);
      add_frame(0, 2, 1'b0, 32'h30);
      add_frame(1, 2, 1'b0, 32'h40);
      drain(60);
      chk("tie_frames", 64'(owner_log.size()), 64'd4);
      if (owner_log.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("tie_order", 64'(owner_log[i]), 64'((i % 2) + 1));
      end
      chk("tie_cnt0", 64'(frame_cnt0), 64'd2);
      chk("tie_cnt1", 64'(frame_cnt1), 64'd2);

      // Backpressure: tready low for 3 cycles while beat 2 of an s1 frame is offered.
      do_reset(1);
      tr_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      add_frame(1, 4, 1'b0, 32'hA0);
      drain(50);
      chk("bp_cnt1", 64'(frame_cnt1), 64'd1);

      // Lockout: s1 requests during an 8-beat s0 frame.
      do_reset(1);
      add_frame(0, 8, 1'b1, 32'd0);
      repeat (3) cycle();
      add_frame(1, 3, 1'b1, 32'd0);
      drain(80);
      chk("lock_frames", 64'(owner_log.size()), 64'd2);
      if (owner_log.size() == 2) begin
         chk("lock_first", 64'(owner_log[0]), 64'd1);
         chk("lock_second", 64'(owner_log[1]), 64'd2);
      end

      // Reset mid-frame after beat 2 of 4, then arbitration restarts.
      do_reset(1);
      acc0 = 0;
      add_frame(0, 4, 1'b0, 32'h100);
      n = 0;
      while (acc0 < 2 && n < 50) begin
         cycle();
         n++;
      end
      chk("rst_mid_reached", 64'(acc0), 64'd2);
      do_reset(1);
      chk("rst_mid_grant", 64'(grant), 64'd0);
      chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_mid_cnt0", 64'(frame_cnt0), 64'd0);
      add_frame(1, 2, 1'b1, 32'd0);
      add_frame(0, 1, 1'b1, 32'd0);
      drain(50);

      // Randomized traffic with gaps and random backpressure.
      do_reset(1);
      gap_pct = 30;
      tr_rand = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if (drv_q0.size() < 3 && $urandom_range(3) == 0) add_frame(0, int'($urandom_range(5, 1)), 1'b1, 32'd0);
         if (drv_q1.size() < 3 && $urandom_range(3) == 0) add_frame(1, int'($urandom_range(5, 1)), 1'b1, 32'd0);
         cycle();
      end
      drain(500);
      chk("rand_exp0_empty", 64'(exp_q0.size()), 64'd0);
      chk("rand_exp1_empty", 64'(exp_q1.size()), 64'd0);

      // Counter wrap: single-beat s0 frames up to 0xFFFF, then one more.
      gap_pct = 0;
      tr_rand = 1'b0;
      n = 0;
      while (mdl_cnt0 != 16'hFFFF && n < 140000) begin
         need = 65535 - int'(mdl_cnt0) - drv_q0.size();
         if (drv_q0.size() < 2 && need > 0) add_frame(0, 1, 1'b1, 32'd0);
         cycle();
         n++;
      end
      chk("wrap_pre", 64'(frame_cnt0), 64'hFFFF);
      add_frame(0, 1, 1'b1, 32'd0);
      drain(20);
      chk("wrap_post", 64'(frame_cnt0), 64'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
